// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer slice.
//   - State encoding (IDLE=0, FETCH=1, DECODE=2, ISSUE=3, HALTED=4, WAIT_STEP=5)
//   - HALT opcode value
//   - Opcode/operand field position helpers, derived from the instruction width
package fetch_sequencer_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FETCH     = 3'd1;
  localparam logic [2:0] ST_DECODE    = 3'd2;
  localparam logic [2:0] ST_ISSUE     = 3'd3;
  localparam logic [2:0] ST_HALTED    = 3'd4;
  localparam logic [2:0] ST_WAIT_STEP = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_FETCH     = ST_FETCH,
    S_DECODE    = ST_DECODE,
    S_ISSUE     = ST_ISSUE,
    S_HALTED    = ST_HALTED,
    S_WAIT_STEP = ST_WAIT_STEP
  } state_t;

  localparam int              OPC_W    = 5;
  localparam logic [OPC_W-1:0] OPC_HALT = 5'b00000;

  // Opcode occupies the top OPC_W bits, operand the remainder.
  function automatic int opc_msb(input int db);
    return db - 1;
  endfunction

  function automatic int opc_lsb(input int db);
    return db - OPC_W;
  endfunction

  function automatic int opr_msb(input int db);
    return db - OPC_W - 1;
  endfunction

endpackage

// File: rtl/fetch_sequencer_counter.sv
// fetch_seq_counter: saturating retired-instruction counter.
// Ports:
//   clk   - clock
//   clr   - synchronous clear (active-high)
//   en    - count one event this cycle
//   count - current count, sticks at all-ones
module fetch_seq_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: drives the synchronous program memory address, captures
// the returned instruction and hands it downstream with valid/ready.
// A HALT opcode parks the sequencer; a start pulse resumes at pc+1.
//
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   start           - begin from IDLE / resume from HALTED
//   pm_addr/pm_data - program memory address (= pc) and read data (1-cycle latency)
//   instr, instr_valid, instr_ready - downstream handshake
//   pc              - address of current/last instruction
//   busy, halted    - status flags
//   retired         - saturating count of accepted instructions
//   step, step_mode - only with FETCH_SEQ_SINGLE_STEP_EN: when step_mode=1,
//                     each accepted instruction waits for a step pulse.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int AB = 11,
  parameter int DB = 16,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [AB-1:0] pm_addr,
  input  logic [DB-1:0] pm_data,
  output logic [DB-1:0] instr,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [AB-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic [CW-1:0] retired
`ifdef FETCH_SEQ_SINGLE_STEP_EN
  ,
  input  logic          step,
  input  logic          step_mode
`endif
);

  localparam int OPC_MSB = opc_msb(DB);
  localparam int OPC_LSB = opc_lsb(DB);

  state_t           state;
  logic [OPC_W-1:0] opcode;
  logic             accept;

  assign pm_addr = pc;
  assign opcode  = pm_data[OPC_MSB:OPC_LSB];
  // instr_valid is always 1 in ISSUE, so the handshake only needs ready.
  assign accept  = (state == S_ISSUE) && instr_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pc    <= '0;
            busy  <= 1'b1;
            state <= S_FETCH;
          end
        end
        // Address is held for one cycle; memory captures Mem[pc] at this edge.
        S_FETCH: begin
          state <= S_DECODE;
        end
        S_DECODE: begin
          instr <= pm_data;
          if (opcode == OPC_HALT) begin
            halted <= 1'b1;
            busy   <= 1'b0;
            state  <= S_HALTED;
          end else begin
            instr_valid <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            pc          <= pc + AB'(1);
`ifdef FETCH_SEQ_SINGLE_STEP_EN
            if (step_mode) begin
              busy  <= 1'b0;
              state <= S_WAIT_STEP;
            end else begin
              state <= S_FETCH;
            end
`else
            state <= S_FETCH;
`endif
          end
        end
        // pc still points at the HALT; resume skips past it.
        S_HALTED: begin
          if (start) begin
            halted <= 1'b0;
            busy   <= 1'b1;
            pc     <= pc + AB'(1);
            state  <= S_FETCH;
          end
        end
`ifdef FETCH_SEQ_SINGLE_STEP_EN
        S_WAIT_STEP: begin
          if (step) begin
            busy  <= 1'b1;
            state <= S_FETCH;
          end
        end
`endif
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  fetch_seq_counter #(.CW(CW)) u_retired (
    .clk   (clk),
    .clr   (reset),
    .en    (accept),
    .count (retired)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a program memory array plus an instruction-level
// reference (pc walks the array, HALT parks it, resume skips it).
module tb_fetch_sequencer;

  localparam int AB = 11;
  localparam int DB = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AB-1:0] pm_addr;
  logic [DB-1:0] pm_data;
  logic [DB-1:0] instr;
  logic          instr_valid;
  logic          instr_ready;
  logic [AB-1:0] pc;
  logic          busy;
  logic          halted;
  logic [CW-1:0] retired;
`ifdef FETCH_SEQ_SINGLE_STEP_EN
  logic          step;
  logic          step_mode;
`endif

  logic [DB-1:0] mem [0:(1<<AB)-1];

  // Reference state: expected pc and expected retired count.
  logic [AB-1:0] mpc;
  logic [CW-1:0] mret;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Synchronous program memory: one cycle read latency.
  always @(posedge clk) pm_data <= mem[pm_addr];

  fetch_sequencer #(.AB(AB), .DB(DB), .CW(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pm_addr     (pm_addr),
    .pm_data     (pm_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted),
    .retired     (retired)
`ifdef FETCH_SEQ_SINGLE_STEP_EN
    ,
    .step        (step),
    .step_mode   (step_mode)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DB-1:0] rand_op();
    logic [4:0]  op;
    logic [10:0] arg;
    op  = 5'($urandom_range(31, 1));
    arg = 11'($urandom);
    return {op, arg};
  endfunction

  // Pulse start for one edge; from HALTED the model skips the HALT word.
  task automatic resume();
    start = 1'b1;
    tick();
    start = 1'b0;
    mpc = mpc + AB'(1);
    chk("resume_pc", 32'(pc), 32'(mpc));
  endtask

  // Run until the sequencer parks on a HALT, with random backpressure.
  task automatic execute(input int budget, input int ready_pct);
    int  cyc;
    bit  done;
    bit  hs;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < budget) begin
      instr_ready = ($urandom_range(99) < ready_pct);
      if (instr_valid) begin
        chk("issue_instr", 32'(instr), 32'(mem[mpc]));
        chk("issue_pc", 32'(pc), 32'(mpc));
      end
      hs = instr_valid && instr_ready;
      tick();
      cyc++;
      if (hs) begin
        mpc = mpc + AB'(1);
        if (mret != '1) mret = mret + CW'(1);
        chk("retired", 32'(retired), 32'(mret));
        chk("valid_drop", 32'(instr_valid), 32'(0));
      end
      if (halted) begin
        chk("halt_pc", 32'(pc), 32'(mpc));
        chk("halt_is_halt_op", 32'(mem[mpc][15:11]), 32'(0));
        chk("halt_no_valid", 32'(instr_valid), 32'(0));
        done = 1'b1;
      end
    end
    if (!done) chk("halt_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    reset       = 1'b1;
    start       = 1'b0;
    instr_ready = 1'b0;
`ifdef FETCH_SEQ_SINGLE_STEP_EN
    step        = 1'b0;
    step_mode   = 1'b0;
`endif
    for (int i = 0; i < (1 << AB); i++) mem[i] = rand_op();
    mem[0] = 16'h0000;
    for (int i = 1; i <= 15; i++)
      mem[i] = (i % 2 == 0) ? 16'h0000 : ((i % 4 == 1) ? 16'h0801 : 16'h1002);
    mem[16] = 16'h0000;

    // Reset state
    tick(); tick(); tick();
    reset = 1'b0;
    chk("rst_pc", 32'(pc), 32'(0));
    chk("rst_pm_addr", 32'(pm_addr), 32'(0));
    chk("rst_instr", 32'(instr), 32'(0));
    chk("rst_valid", 32'(instr_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_halted", 32'(halted), 32'(0));
    chk("rst_retired", 32'(retired), 32'(0));
    mpc  = '0;
    mret = '0;

    // HALT at Mem[0]: halted two edges after the start edge
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("h0_busy_fetch", 32'(busy), 32'(1));
    chk("h0_halted_e1", 32'(halted), 32'(0));
    tick();
    chk("h0_halted_e2", 32'(halted), 32'(0));
    chk("h0_valid_e2", 32'(instr_valid), 32'(0));
    tick();
    chk("h0_halted_e3", 32'(halted), 32'(1));
    chk("h0_busy_e3", 32'(busy), 32'(0));
    chk("h0_pc", 32'(pc), 32'(0));
    chk("h0_valid", 32'(instr_valid), 32'(0));
    chk("h0_retired", 32'(retired), 32'(0));

    // Resume to Mem[1]=0801: valid three edges after start
    instr_ready = 1'b1;
    resume();
    tick();
    chk("r1_valid_e2", 32'(instr_valid), 32'(0));
    tick();
    chk("r1_valid_e3", 32'(instr_valid), 32'(1));
    chk("r1_instr", 32'(instr), 32'(16'h0801));
    tick();
    mpc  = mpc + AB'(1);
    mret = mret + CW'(1);
    chk("r1_accept_valid", 32'(instr_valid), 32'(0));
    chk("r1_retired", 32'(retired), 32'(1));
    chk("r1_next_pc", 32'(pc), 32'(2));
    execute(20, 100);

    // Backpressure on Mem[3]=1002 for 5 cycles
    instr_ready = 1'b0;
    resume();
    tick(); tick();
    chk("bp_valid", 32'(instr_valid), 32'(1));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_instr", 32'(instr), 32'(16'h1002));
      chk("bp_valid_hold", 32'(instr_valid), 32'(1));
      chk("bp_pc", 32'(pc), 32'(3));
      chk("bp_pm_addr", 32'(pm_addr), 32'(3));
    end
    instr_ready = 1'b1;
    tick();
    mpc  = mpc + AB'(1);
    mret = mret + CW'(1);
    chk("bp_release_valid", 32'(instr_valid), 32'(0));
    chk("bp_release_pc", 32'(pc), 32'(mpc));
    chk("bp_release_retired", 32'(retired), 32'(mret));
    execute(20, 100);

    // Alternating HALT/non-HALT up to the HALT at Mem[16]
    g = 0;
    while (mpc != AB'(16) && g < 20) begin
      resume();
      execute(100, 70);
      g++;
    end
    chk("alt_reached", 32'(mpc), 32'(16));

    // Random program Mem[17..40], HALT at Mem[41]
    for (int i = 17; i <= 40; i++)
      mem[i] = ($urandom_range(3) == 0) ? 16'h0000 : rand_op();
    mem[41] = 16'h0000;
    mem[42] = 16'h1803;
    g = 0;
    while (mpc != AB'(41) && g < 40) begin
      resume();
      execute(300, 50);
      g++;
    end
    chk("rand_reached", 32'(mpc), 32'(41));

    // Reset in DECODE with pm_data=1803, start asserted together with reset
    resume();
    tick();
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk("rd_pc", 32'(pc), 32'(0));
    chk("rd_instr", 32'(instr), 32'(0));
    chk("rd_valid", 32'(instr_valid), 32'(0));
    chk("rd_busy", 32'(busy), 32'(0));
    chk("rd_retired", 32'(retired), 32'(0));
    tick();
    chk("rd_idle_busy", 32'(busy), 32'(0));
    mpc  = '0;
    mret = '0;

    // start while busy in ISSUE is ignored
    mem[0] = 16'h2805;
    instr_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_valid", 32'(instr_valid), 32'(1));
    chk("ign_pc", 32'(pc), 32'(0));
    chk("ign_instr", 32'(instr), 32'(16'h2805));
    execute(20, 100);

    // Wrap: run to HALT at Mem[2047], resume wraps to Mem[0]
    for (int i = 3; i < (1 << AB) - 1; i++) mem[i] = rand_op();
    mem[(1 << AB) - 1] = 16'h0000;
    resume();
    execute(20000, 100);
    chk("wrap_halt_pc", 32'(pc), 32'((1 << AB) - 1));
    resume();
    chk("wrap_pc0", 32'(pc), 32'(0));
    execute(40, 100);
    chk("wrap_end_pc", 32'(pc), 32'(2));

`ifdef FETCH_SEQ_SINGLE_STEP_EN
    // Single-step: one instruction per step pulse
    step_mode   = 1'b1;
    instr_ready = 1'b1;
    resume();
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      chk("ss_valid", 32'(instr_valid), 32'(1));
      chk("ss_instr", 32'(instr), 32'(mem[mpc]));
      tick();
      mpc  = mpc + AB'(1);
      mret = mret + CW'(1);
      chk("ss_retired", 32'(retired), 32'(mret));
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      chk("ss_wait_valid", 32'(instr_valid), 32'(0));
      chk("ss_wait_busy", 32'(busy), 32'(0));
      chk("ss_wait_pc", 32'(pc), 32'(mpc));
      step = 1'b1;
      tick();
      step = 1'b0;
      tick(); tick();
    end
    step_mode = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
